// File: rtl/viterbi_codec_k3.sv
// Rate-1/2, K=3 convolutional encoder (g0=111, g1=101) and a 4-state
// hard-decision Viterbi decoder using register-exchange survivors.
// Encoder and decoder paths are fully independent.
module viterbi_codec_k3 #(
  parameter int TB_DEPTH = 16,
  parameter int METRIC_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_in,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_out,
  input  logic       dec_enable,
  input  logic [1:0] dec_d_in,
  output logic       dec_valid_o,
  output logic       dec_d_out
);

  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [METRIC_W-1:0] PM_MAX  = '1;
  // Non-zero start states are penalised so decoding begins from state 00.
  localparam logic [METRIC_W-1:0] PM_INIT = (METRIC_W > 4) ? METRIC_W'(16) : PM_MAX;
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(TB_DEPTH);

  // Saturating metric add: a path metric can never wrap around.
  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] a,
                                                  input logic [1:0] b);
    logic [METRIC_W:0] s;
    s = {1'b0, a} + {{(METRIC_W-1){1'b0}}, b};
    return s[METRIC_W] ? PM_MAX : s[METRIC_W-1:0];
  endfunction

  // Hamming distance between two 2-bit symbols.
  function automatic logic [1:0] ham2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

  // Code symbol produced when bit b enters from state st = {s1,s0}.
  function automatic logic [1:0] exp_sym(input logic [1:0] st, input logic b);
    return {b ^ st[0] ^ st[1], b ^ st[1]};
  endfunction

  // ---------------- encoder ----------------
  logic [1:0] enc_s_q, enc_s_d;
  logic [1:0] enc_out_q, enc_out_d;
  logic       enc_vld_q, enc_vld_d;

  // Encoder next state: shift the new bit into s0, hold when disabled.
  always_comb begin
    enc_s_d   = enc_s_q;
    enc_out_d = enc_out_q;
    enc_vld_d = enc_enable_i;
    if (enc_enable_i) begin
      enc_out_d = exp_sym(enc_s_q, enc_d_in);
      enc_s_d   = {enc_s_q[0], enc_d_in};
    end
  end

  // Encoder registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_s_q   <= '0;
      enc_out_q <= '0;
      enc_vld_q <= 1'b0;
    end else begin
      enc_s_q   <= enc_s_d;
      enc_out_q <= enc_out_d;
      enc_vld_q <= enc_vld_d;
    end
  end

  assign enc_valid_o = enc_vld_q;
  assign enc_d_out   = enc_out_q;

  // ---------------- decoder ----------------
  logic [METRIC_W-1:0] pm_q [4];
  logic [METRIC_W-1:0] pm_d [4];
  logic [TB_DEPTH-1:0] path_q [4];
  logic [TB_DEPTH-1:0] path_d [4];
  logic [METRIC_W-1:0] cand_a [4];
  logic [METRIC_W-1:0] cand_b [4];
  logic [METRIC_W-1:0] acs_m [4];
  logic [TB_DEPTH-1:0] acs_p [4];
  logic [METRIC_W-1:0] min_m;
  logic [1:0]          best;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                dout_q, dout_d;
  logic                dvld_q, dvld_d;

  // Add-compare-select for next state ns={s0,b}: predecessors are {0,s0} and
  // {1,s0}; ties go to the s1=0 predecessor. Then pick the best state,
  // normalise metrics and advance the survivors.
  always_comb begin
    for (int ns = 0; ns < 4; ns++) begin
      cand_a[ns] = sat_add(pm_q[ns/2],
                           ham2(dec_d_in, exp_sym(2'(ns/2), 1'(ns))));
      cand_b[ns] = sat_add(pm_q[2 + ns/2],
                           ham2(dec_d_in, exp_sym(2'(2 + ns/2), 1'(ns))));
      if (cand_b[ns] < cand_a[ns]) begin
        acs_m[ns] = cand_b[ns];
        acs_p[ns] = {path_q[2 + ns/2][TB_DEPTH-2:0], 1'(ns)};
      end else begin
        acs_m[ns] = cand_a[ns];
        acs_p[ns] = {path_q[ns/2][TB_DEPTH-2:0], 1'(ns)};
      end
    end

    min_m = acs_m[0];
    best  = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (acs_m[i] < min_m) begin
        min_m = acs_m[i];
        best  = 2'(i);
      end
    end

    cnt_inc = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;

    for (int i = 0; i < 4; i++) begin
      pm_d[i]   = pm_q[i];
      path_d[i] = path_q[i];
    end
    cnt_d  = cnt_q;
    dout_d = dout_q;
    dvld_d = 1'b0;
    if (dec_enable) begin
      for (int i = 0; i < 4; i++) begin
        pm_d[i]   = acs_m[i] - min_m;
        path_d[i] = acs_p[i];
      end
      cnt_d  = cnt_inc;
      dout_d = acs_p[best][TB_DEPTH-1];
      dvld_d = (cnt_inc == CNT_FULL);
    end
  end

  // Decoder registers: metrics, survivors, fill counter and output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_q[0] <= '0;
      pm_q[1] <= PM_INIT;
      pm_q[2] <= PM_INIT;
      pm_q[3] <= PM_INIT;
      for (int i = 0; i < 4; i++) path_q[i] <= '0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
      dvld_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= pm_d[i];
        path_q[i] <= path_d[i];
      end
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      dvld_q <= dvld_d;
    end
  end

  assign dec_valid_o = dvld_q;
  assign dec_d_out   = dout_q;

endmodule

// File: tb/tb_viterbi_codec_k3.sv
// Bench for viterbi_codec_k3: encoder vector table, then random streams
// through encoder -> 1-cycle channel register -> decoder.
module tb_viterbi_codec_k3;

  localparam int TBD = 16;

  logic       clk;
  logic       rst;
  logic       enc_enable_i;
  logic       enc_d_in;
  logic       enc_valid_o;
  logic [1:0] enc_d_out;
  logic       dec_enable;
  logic [1:0] dec_d_in;
  logic       dec_valid_o;
  logic       dec_d_out;

  viterbi_codec_k3 #(.TB_DEPTH(TBD), .METRIC_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_in     (enc_d_in),
    .enc_valid_o  (enc_valid_o),
    .enc_d_out    (enc_d_out),
    .dec_enable   (dec_enable),
    .dec_d_in     (dec_d_in),
    .dec_valid_o  (dec_valid_o),
    .dec_d_out    (dec_d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  typedef struct {
    logic       en;
    logic       d;
    logic       vld;
    logic [1:0] sym;
  } enc_vec_t;

  enc_vec_t vt [15];

  bit         src  [$];
  logic [1:0] errm [$];
  bit         decq [$];

  task automatic do_reset();
    rst          = 1'b0;
    enc_enable_i = 1'b0;
    enc_d_in     = 1'b0;
    dec_enable   = 1'b0;
    dec_d_in     = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Reference code symbol k of src, computed from the generator polynomials.
  function automatic logic [1:0] ref_sym(input int k);
    bit d0, d1, d2;
    d0 = src[k];
    d1 = (k >= 1) ? src[k-1] : 1'b0;
    d2 = (k >= 2) ? src[k-2] : 1'b0;
    return {d0 ^ d1 ^ d2, d0 ^ d2};
  endfunction

  // emode: 0 clean, 1 sparse single-symbol errors, 2 two-symbol bursts.
  // abort_at >= 0 stops feeding after that many encoder bits (for mid-stream reset).
  task automatic run_stream(input string tag, input int n, input bit gate,
                            input int emode, input int abort_at, input bit rst_first);
    int   len, fed, ncyc, decen, first_en, enc_seen, enc_bad, gate_bad, errs, cmp_bad, pos, m;
    bit   chan_v, norm_ok, clean;
    logic [1:0] chan_s;
    logic en;

    src.delete(); errm.delete(); decq.delete();
    for (int i = 0; i < n; i++) src.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < TBD - 1; i++) src.push_back(1'b0);
    len = src.size();
    for (int i = 0; i < len; i++) errm.push_back(2'b00);
    if (emode == 1) begin
      pos = 5 + $urandom_range(0, 9);
      while (pos < n) begin
        errm[pos] = 2'b11;
        pos += 20 + $urandom_range(0, 9);
      end
    end else if (emode == 2) begin
      pos = 0;
      while (pos + 1 < n) begin
        if ($urandom_range(0, 31) == 0) begin
          errm[pos]   = 2'b11;
          errm[pos+1] = 2'b11;
          pos += 2;
        end else begin
          pos += 1;
        end
      end
    end

    if (rst_first) do_reset();
    fed = 0; ncyc = 0; decen = 0; first_en = -1; enc_seen = 0;
    enc_bad = 0; gate_bad = 0; chan_v = 1'b0; chan_s = 2'b00; norm_ok = 1'b1;

    while (decq.size() < n && ncyc < 4 * len + 100) begin
      if (abort_at >= 0 && fed == abort_at) break;
      en = (fed < len) && (!gate || (ncyc % 2 == 0));
      enc_enable_i = en;
      enc_d_in     = en ? src[fed] : 1'($urandom_range(0, 1));
      dec_enable   = chan_v;
      dec_d_in     = chan_v ? chan_s : 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      if (en) fed++;
      if (dec_enable) begin
        decen++;
        m = 1000;
        for (int j = 0; j < 4; j++) if (int'(dut.pm_q[j]) < m) m = int'(dut.pm_q[j]);
        if (m != 0) norm_ok = 1'b0;
      end else if (dec_valid_o) begin
        gate_bad++;
      end
      if (dec_valid_o) begin
        if (first_en < 0) first_en = decen;
        decq.push_back(dec_d_out);
      end
      chan_v = enc_valid_o;
      if (enc_valid_o) begin
        if (enc_seen >= len || enc_d_out !== ref_sym(enc_seen)) enc_bad++;
        chan_s = enc_d_out ^ ((enc_seen < len) ? errm[enc_seen] : 2'b00);
        enc_seen++;
      end
      ncyc++;
    end
    enc_enable_i = 1'b0;
    dec_enable   = 1'b0;

    check({tag, "_enc_syms"}, enc_bad, 0);
    check({tag, "_valid_when_idle"}, gate_bad, 0);
    check({tag, "_first_valid_enable"}, first_en, TBD);
    check({tag, "_min_metric_zero"}, int'(norm_ok), 1);
    if (abort_at >= 0) return;

    check({tag, "_decoded_count"}, (decq.size() >= n) ? 1 : 0, 1);
    errs = 0; cmp_bad = 0;
    for (int i = 0; i < n && i < decq.size(); i++) begin
      clean = 1'b1;
      for (int k = i - 32; k <= i + TBD; k++)
        if (k >= 0 && k < len && errm[k] != 2'b00) clean = 1'b0;
      if (decq[i] != src[i]) begin
        errs++;
        if (emode != 2 || clean) cmp_bad++;
      end
    end
    if (emode == 2) $display("%s: decoded bit errors = %0d", tag, errs);
    check({tag, "_decoded_bits"}, cmp_bad, 0);
  endtask

  initial begin
    rst          = 1'b0;
    enc_enable_i = 1'b0;
    enc_d_in     = 1'b0;
    dec_enable   = 1'b0;
    dec_d_in     = 2'b00;
    #1;
    check("reset_enc_valid", int'(enc_valid_o), 0);
    check("reset_enc_out", int'(enc_d_out), 0);
    check("reset_dec_valid", int'(dec_valid_o), 0);
    check("reset_dec_out", int'(dec_d_out), 0);

    // impulse response, then mixed bits with enable gaps (outputs hold)
    vt[0]  = '{1'b1, 1'b1, 1'b1, 2'b11};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 2'b10};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 2'b11};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 2'b00};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 2'b11};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 2'b10};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 2'b11};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 2'b00};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 2'b00};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 2'b11};
    vt[10] = '{1'b1, 1'b1, 1'b1, 2'b01};
    vt[11] = '{1'b0, 1'b0, 1'b0, 2'b01};
    vt[12] = '{1'b1, 1'b1, 1'b1, 2'b10};
    vt[13] = '{1'b1, 1'b0, 1'b1, 2'b01};
    vt[14] = '{1'b1, 1'b0, 1'b1, 2'b11};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      enc_enable_i = vt[i].en;
      enc_d_in     = vt[i].d;
      @(posedge clk);
      #1;
      check($sformatf("enc_vec%0d_valid", i), int'(enc_valid_o), int'(vt[i].vld));
      check($sformatf("enc_vec%0d_sym", i), int'(enc_d_out), int'(vt[i].sym));
    end
    enc_enable_i = 1'b0;
    @(posedge clk);
    #1;
    check("enc_valid_drop", int'(enc_valid_o), 0);
    check("dec_idle_valid", int'(dec_valid_o), 0);

    run_stream("loop", 256, 1'b0, 0, -1, 1'b1);
    run_stream("gated", 200, 1'b1, 0, -1, 1'b1);
    run_stream("sparse", 256, 1'b0, 1, -1, 1'b1);
    run_stream("sparse_gated", 256, 1'b1, 1, -1, 1'b1);

    // reset asserted mid-stream, outputs must clear without waiting for an edge
    run_stream("pre_rst", 256, 1'b0, 0, 100, 1'b1);
    check("pre_rst_dec_valid_high", int'(dec_valid_o), 1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_enc_valid", int'(enc_valid_o), 0);
    check("midrst_enc_out", int'(enc_d_out), 0);
    check("midrst_dec_valid", int'(dec_valid_o), 0);
    check("midrst_dec_out", int'(dec_d_out), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_stream("post_rst", 156, 1'b0, 0, -1, 1'b0);

    run_stream("burst", 256, 1'b0, 2, -1, 1'b1);
    run_stream("burst2", 256, 1'b0, 2, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
